// File: rtl/cw305_trace_reg_fifo.sv
// Project register block behind the CW305 USB front-end: ID/CTRL/scratch registers
// plus a first-word-fall-through trace FIFO that the host drains byte-wise.
module cw305_trace_reg_fifo #(
  parameter int unsigned pADDR_WIDTH   = 21,
  parameter int unsigned pBYTECNT_SIZE = 7,
  parameter int unsigned pFIFO_DEPTH   = 512,
  parameter logic [7:0]  pID           = 8'h5A
) (
  input  logic                                 usb_clk,
  input  logic                                 rst_n,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
  input  logic [7:0]                           reg_datao,
  output logic [7:0]                           reg_datai,
  input  logic                                 reg_read,
  input  logic                                 reg_write,
  input  logic                                 reg_addrvalid,
  input  logic [31:0]                          trace_data,
  input  logic                                 trace_valid,
  output logic                                 trace_arm,
  output logic                                 fifo_full,
  output logic                                 fifo_overflow
);

  localparam int unsigned AW = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int unsigned BW = pBYTECNT_SIZE;
  localparam int unsigned PW = $clog2(pFIFO_DEPTH);

  localparam logic [AW-1:0] lpADDR_ID      = AW'(0);
  localparam logic [AW-1:0] lpADDR_CTRL    = AW'(1);
  localparam logic [AW-1:0] lpADDR_STAT    = AW'(2);
  localparam logic [AW-1:0] lpADDR_DATA    = AW'(3);
  localparam logic [AW-1:0] lpADDR_SCRATCH = AW'(4);
  localparam logic [PW:0]   lpDEPTH        = (PW+1)'(pFIFO_DEPTH);

  logic [7:0]  r_datai;
  logic        r_arm;
  logic [31:0] r_scratch;
  logic        r_read_q;
  logic        r_pop_tgt;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          r_overflow;
  logic [31:0]   r_mem [pFIFO_DEPTH];

  logic        w_byte0;
  logic        w_word_byte;
  logic [1:0]  w_bsel;
  logic        w_wr;
  logic        w_flush;
  logic        w_full;
  logic        w_empty;
  logic        w_read_rise;
  logic        w_read_fall;
  logic        w_pop;
  logic        w_push_req;
  logic        w_push;
  logic [31:0] w_head;
  logic [31:0] w_stat;
  logic [15:0] w_count16;
  logic [7:0]  w_rdata;

  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  assign w_byte0     = (reg_bytecnt == BW'(0));
  assign w_word_byte = (reg_bytecnt < BW'(4));
  assign w_bsel      = reg_bytecnt[1:0];
  assign w_wr        = reg_write && reg_addrvalid;
  assign w_flush     = w_wr && (reg_address == lpADDR_CTRL) && w_byte0 && reg_datao[1];

  assign w_full      = (r_count == lpDEPTH);
  assign w_empty     = (r_count == '0);
  assign w_count16   = 16'(r_count);
  assign w_head      = w_empty ? 32'h0 : r_mem[r_rptr];
  assign w_stat      = {8'h00, w_count16, 5'b0, r_overflow, w_full, w_empty};

  // Pop on the trailing edge of the strobe so the byte-3 read itself sees the old head.
  assign w_read_rise = reg_read && !r_read_q;
  assign w_read_fall = !reg_read && r_read_q;
  assign w_pop       = !w_flush && w_read_fall && r_pop_tgt && !w_empty;
  assign w_push_req  = !w_flush && trace_valid && r_arm;
  assign w_push      = w_push_req && (!w_full || w_pop);

  always_comb begin
    w_rdata = 8'h00;
    if (reg_addrvalid) begin
      case (reg_address)
        lpADDR_ID:      if (w_byte0) w_rdata = pID;
        lpADDR_CTRL:    if (w_byte0) w_rdata = {7'b0, r_arm};
        lpADDR_STAT:    if (w_word_byte) w_rdata = byte_of(w_stat, w_bsel);
        lpADDR_DATA:    if (w_word_byte) w_rdata = byte_of(w_head, w_bsel);
        lpADDR_SCRATCH: if (w_word_byte) w_rdata = byte_of(r_scratch, w_bsel);
        default:        w_rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_datai   <= 8'h00;
      r_arm     <= 1'b0;
      r_scratch <= 32'h0;
      r_read_q  <= 1'b0;
      r_pop_tgt <= 1'b0;
    end else begin
      r_datai  <= w_rdata;
      r_read_q <= reg_read;
      if (w_read_rise) begin
        r_pop_tgt <= reg_addrvalid && (reg_address == lpADDR_DATA) && (reg_bytecnt == BW'(3));
      end else if (w_read_fall) begin
        r_pop_tgt <= 1'b0;
      end
      if (w_wr && (reg_address == lpADDR_CTRL) && w_byte0) begin
        r_arm <= reg_datao[0];
      end
      if (w_wr && (reg_address == lpADDR_SCRATCH) && w_word_byte) begin
        case (w_bsel)
          2'd0:    r_scratch[7:0]   <= reg_datao;
          2'd1:    r_scratch[15:8]  <= reg_datao;
          2'd2:    r_scratch[23:16] <= reg_datao;
          default: r_scratch[31:24] <= reg_datao;
        endcase
      end
    end
  end

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push_req && !w_push) r_overflow <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge usb_clk) begin
    if (w_push) r_mem[r_wptr] <= trace_data;
  end

  assign reg_datai     = r_datai;
  assign trace_arm     = r_arm;
  assign fifo_full     = w_full;
  assign fifo_overflow = r_overflow;

endmodule

// File: tb/tb_cw305_trace_reg_fifo.sv
// Directed bench for cw305_trace_reg_fifo: read expectations go through a scoreboard queue,
// FIFO contents are tracked by a word-queue model.
module tb_cw305_trace_reg_fifo;
  localparam int AW    = 14;
  localparam int BW    = 7;
  localparam int DEPTH = 512;

  logic          usb_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] reg_address = '0;
  logic [BW-1:0] reg_bytecnt = '0;
  logic [7:0]    reg_datao = '0;
  logic [7:0]    reg_datai;
  logic          reg_read = 1'b0;
  logic          reg_write = 1'b0;
  logic          reg_addrvalid = 1'b0;
  logic [31:0]   trace_data = '0;
  logic          trace_valid = 1'b0;
  logic          trace_arm;
  logic          fifo_full;
  logic          fifo_overflow;

  int checks = 0;
  int failures = 0;
  logic [7:0]  sb[$];
  logic [31:0] mdl[$];
  bit arm_m = 1'b0;
  bit ovf_m = 1'b0;

  cw305_trace_reg_fifo #(
    .pADDR_WIDTH  (21),
    .pBYTECNT_SIZE(7),
    .pFIFO_DEPTH  (DEPTH),
    .pID          (8'h5A)
  ) dut (
    .usb_clk      (usb_clk),
    .rst_n        (rst_n),
    .reg_address  (reg_address),
    .reg_bytecnt  (reg_bytecnt),
    .reg_datao    (reg_datao),
    .reg_datai    (reg_datai),
    .reg_read     (reg_read),
    .reg_write    (reg_write),
    .reg_addrvalid(reg_addrvalid),
    .trace_data   (trace_data),
    .trace_valid  (trace_valid),
    .trace_arm    (trace_arm),
    .fifo_full    (fifo_full),
    .fifo_overflow(fifo_overflow)
  );

  always #5 usb_clk = ~usb_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dexp(input int b);
    logic [31:0] w;
    if (mdl.size() == 0) return 8'h00;
    w = mdl[0];
    return w[8*b +: 8];
  endfunction

  task automatic rd(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [7:0] exp,
                    input string tag, input int hold = 1);
    logic [7:0] e;
    @(negedge usb_clk);
    reg_address = a; reg_bytecnt = b; reg_addrvalid = 1'b1; reg_read = 1'b1;
    sb.push_back(exp);
    repeat (hold) @(negedge usb_clk);
    e = sb.pop_front();
    check(tag, {24'h0, reg_datai}, {24'h0, e});
    reg_read = 1'b0;
    @(negedge usb_clk);
    reg_addrvalid = 1'b0;
    if (a == AW'(3) && b == BW'(3) && mdl.size() > 0) void'(mdl.pop_front());
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [7:0] d,
                    input int cycles = 1);
    @(negedge usb_clk);
    reg_address = a; reg_bytecnt = b; reg_datao = d; reg_addrvalid = 1'b1; reg_write = 1'b1;
    repeat (cycles) @(negedge usb_clk);
    reg_write = 1'b0; reg_addrvalid = 1'b0;
    if (a == AW'(1) && b == BW'(0)) begin
      arm_m = d[0];
      if (d[1]) begin mdl.delete(); ovf_m = 1'b0; end
    end
  endtask

  task automatic push(input logic [31:0] w);
    @(negedge usb_clk);
    trace_data = w; trace_valid = 1'b1;
    @(negedge usb_clk);
    trace_valid = 1'b0;
    if (arm_m) begin
      if (mdl.size() < DEPTH) mdl.push_back(w);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic chk_stat(input string tag);
    logic [15:0] n;
    n = 16'(mdl.size());
    rd(AW'(2), BW'(0), {5'b0, ovf_m, mdl.size() == DEPTH, mdl.size() == 0}, {tag, "_b0"});
    rd(AW'(2), BW'(1), n[7:0], {tag, "_b1"});
    rd(AW'(2), BW'(2), n[15:8], {tag, "_b2"});
    rd(AW'(2), BW'(3), 8'h00, {tag, "_b3"});
  endtask

  task automatic rd_word(input string tag, input int hold3 = 1);
    for (int b = 0; b < 3; b++) rd(AW'(3), BW'(b), dexp(b), tag);
    rd(AW'(3), BW'(3), dexp(3), tag, hold3);
  endtask

  initial begin
    logic [7:0] sc [4];
    sc[0] = 8'h11; sc[1] = 8'h22; sc[2] = 8'h33; sc[3] = 8'h44;

    #1;
    check("rst_datai", {24'h0, reg_datai}, 32'h0);
    check("rst_arm", {31'h0, trace_arm}, 32'h0);
    check("rst_full", {31'h0, fifo_full}, 32'h0);
    check("rst_ovf", {31'h0, fifo_overflow}, 32'h0);
    repeat (2) @(negedge usb_clk);
    rst_n = 1'b1;

    rd(AW'(0), BW'(0), 8'h5A, "id");
    rd(AW'(0), BW'(1), 8'h00, "id_b1");
    chk_stat("stat_reset");
    rd(AW'(7), BW'(0), 8'h00, "unmapped");
    wr(AW'(7), BW'(0), 8'hFF);
    rd(AW'(7), BW'(0), 8'h00, "unmapped_wr");
    wr(AW'(0), BW'(0), 8'h00);
    rd(AW'(0), BW'(0), 8'h5A, "id_ro");

    for (int b = 0; b < 4; b++) wr(AW'(4), BW'(b), sc[b], 3);
    for (int b = 0; b < 4; b++) rd(AW'(4), BW'(b), sc[b], "scratch");
    rd(AW'(4), BW'(4), 8'h00, "scratch_b4");

    rd(AW'(1), BW'(0), 8'h00, "ctrl_rst");
    wr(AW'(1), BW'(0), 8'h03);
    rd(AW'(1), BW'(0), 8'h01, "ctrl_bit1");
    check("arm_on", {31'h0, trace_arm}, 32'h1);

    push(32'hA1B2C3D4);
    push(32'h01020304);
    chk_stat("stat_two");
    rd_word("data_w0");
    chk_stat("stat_one");
    rd_word("data_w1", 5);
    chk_stat("stat_zero");
    rd(AW'(3), BW'(3), 8'h00, "data_empty");
    chk_stat("stat_empty_pop");

    for (int i = 0; i < DEPTH + 3; i++) push(32'hC0DE0000 + 32'(i));
    check("full_flag", {31'h0, fifo_full}, 32'h1);
    check("ovf_flag", {31'h0, fifo_overflow}, 32'h1);
    chk_stat("stat_full");
    rd_word("first_word");
    chk_stat("stat_after_pop");
    wr(AW'(1), BW'(0), 8'h03);
    check("flush_ovf", {31'h0, fifo_overflow}, 32'h0);
    check("flush_arm", {31'h0, trace_arm}, 32'h1);
    chk_stat("stat_flush");

    for (int i = 0; i < DEPTH; i++) push(32'h5EED0000 + 32'(i));
    check("refill_full", {31'h0, fifo_full}, 32'h1);
    check("refill_ovf", {31'h0, fifo_overflow}, 32'h0);
    // Pop (strobe falling edge) and push land on the same clock edge.
    @(negedge usb_clk);
    reg_address = AW'(3); reg_bytecnt = BW'(3); reg_addrvalid = 1'b1; reg_read = 1'b1;
    @(negedge usb_clk);
    reg_read = 1'b0; trace_data = 32'hFEEDBEEF; trace_valid = 1'b1;
    @(negedge usb_clk);
    trace_valid = 1'b0; reg_addrvalid = 1'b0;
    void'(mdl.pop_front());
    mdl.push_back(32'hFEEDBEEF);
    check("pp_full", {31'h0, fifo_full}, 32'h1);
    check("pp_ovf", {31'h0, fifo_overflow}, 32'h0);
    chk_stat("stat_pp");
    for (int b = 0; b < 4; b++) rd(AW'(3), BW'(b), dexp(b), "pp_head");

    rd(AW'(3), BW'(3), dexp(3), "pop_one");
    wr(AW'(1), BW'(0), 8'h00);
    check("disarm", {31'h0, trace_arm}, 32'h0);
    for (int i = 0; i < 3; i++) push(32'hDEAD0000 + 32'(i));
    chk_stat("stat_disarmed");

    wr(AW'(1), BW'(0), 8'h03);
    push(32'h12345678);
    push(32'h9ABCDEF0);
    chk_stat("stat_pre_rst");
    @(negedge usb_clk);
    reg_address = AW'(3); reg_bytecnt = BW'(3); reg_addrvalid = 1'b1; reg_read = 1'b1;
    repeat (2) @(negedge usb_clk);
    rst_n = 1'b0;
    #1;
    check("midrd_datai", {24'h0, reg_datai}, 32'h0);
    check("midrd_arm", {31'h0, trace_arm}, 32'h0);
    @(negedge usb_clk);
    rst_n = 1'b1;
    mdl.delete(); arm_m = 1'b0; ovf_m = 1'b0;
    @(negedge usb_clk);
    check("post_rst_datai", {24'h0, reg_datai}, 32'h0);
    reg_read = 1'b0;
    @(negedge usb_clk);
    reg_addrvalid = 1'b0;
    chk_stat("stat_post_rst");
    rd(AW'(4), BW'(0), 8'h00, "scratch_rst");
    rd(AW'(1), BW'(0), 8'h00, "ctrl_rst2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cw305_trace_reg_fifo.md
Name: cw305_trace_reg_fifo

Overview:
Project register block placed directly downstream of the USB register front-end. It consumes that block's reg_address, reg_bytecnt, reg_datao, reg_read and reg_write strobes, and returns read data on reg_datai. It holds the control, status and scratch registers. It also buffers 32-bit trace words from the capture logic in a FIFO that the host drains byte-wise over USB. Everything runs in the usb_clk domain.

Parameters:
pADDR_WIDTH, 21, full USB address width; must match the front-end.
pBYTECNT_SIZE, 7, byte-count field width; must match the front-end.
pFIFO_DEPTH, 512, trace FIFO depth in 32-bit words; power of two, 4..32768.
pID, 8'h5A, constant returned by REG_ID.

Ports:
usb_clk  in  1  sole clock.
rst_n  in  1  asynchronous active-low reset.
reg_address  in  pADDR_WIDTH-pBYTECNT_SIZE  register select.
reg_bytecnt  in  pBYTECNT_SIZE  byte within register, little-endian.
reg_datao  in  8  write data from the front-end.
reg_datai  out  8  read data to the front-end.
reg_read  in  1  read strobe; held high for the whole host read.
reg_write  in  1  write strobe; may be high for several consecutive cycles.
reg_addrvalid  in  1  address valid; reads and writes are decoded only while it is high.
trace_data  in  32  trace word from the capture logic.
trace_valid  in  1  trace_data is offered this cycle.
trace_arm  out  1  CTRL bit0; capture logic pushes only while this is high.
fifo_full  out  1  FIFO is at pFIFO_DEPTH.
fifo_overflow  out  1  sticky flag: a word was dropped.

Behaviour:
- Register map (reg_address value: access, size):
  - 0 REG_ID: RO, 1 byte, returns pID.
  - 1 REG_CTRL: RW, 1 byte. bit0 = arm. bit1 = flush, self-clearing and always read as 0. Other bits read as 0.
  - 2 REG_FIFO_STAT: RO, 4 bytes. byte0 = {5'b0, overflow, full, empty}. bytes1-2 = word count, zero-extended to 16 bits. byte3 = 0.
  - 3 REG_FIFO_DATA: RO, 4 bytes. Returns the head word (first-word-fall-through), byte N = word[8N+7:8N].
  - 4 REG_SCRATCH: RW, 4 bytes.
  - Unmapped addresses and out-of-range bytes read 0; writes to them are ignored.
- Read path:
  - reg_datai is registered: it is updated every cycle from the current reg_address/reg_bytecnt mux. Data is therefore valid one cycle after the inputs, which satisfies the front-end's one-cycle-after-reg_read rule.
  - reg_datai resets to 0.
- Write path: on each cycle with reg_write && reg_addrvalid, the addressed byte is loaded from reg_datao. Repeated cycles are idempotent.
- Flush:
  - Any write cycle to REG_CTRL with reg_datao[1]=1 resets both pointers, count and overflow in the next cycle.
  - Flush has priority over a same-cycle push or pop.
- Push: when trace_valid && trace_arm:
  - If not full (or a pop in the same cycle frees a slot), the word is stored at the write pointer, which then advances.
  - Otherwise the word is dropped and overflow is set.
  - trace_valid with arm=0 is ignored and does not set overflow.
- Pop:
  - At the start of each read (reg_read rising edge) the block latches whether the target is REG_FIFO_DATA byte 3.
  - On the reg_read falling edge, if that latch is set and the FIFO is not empty, the read pointer advances by one. Exactly one pop occurs per host read, regardless of strobe length.
  - A pop on an empty FIFO is ignored; the data then reads 0.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, a same-cycle pop frees a slot, so the push is accepted.
- Pointers are log2(pFIFO_DEPTH) bits and wrap modulo depth. Count is log2(pFIFO_DEPTH)+1 bits, range 0..pFIFO_DEPTH.
- Flags: full = (count==pFIFO_DEPTH); empty = (count==0).
- Storage is an inferred RAM, not reset.
- Asynchronous reset (rst_n=0), at any time including mid-read, clears: CTRL (arm=0), scratch, pointers, count, overflow, the pop latch and reg_datai. After reset, empty=1 and full=0.

Test Plan:
- Reset, read REG_ID byte0 and REG_FIFO_STAT byte0 -> 0x5A and 0x01 (empty).
- Write REG_SCRATCH bytes 0-3 = 11,22,33,44 with a 3-cycle reg_write each, then read back -> 0x11,0x22,0x33,0x44; REG_CTRL bit1 reads 0.
- Arm, push 0xA1B2C3D4 and 0x01020304, read DATA bytes 0-3 twice -> D4,C3,B2,A1 then 04,03,02,01; STAT count goes 2 -> 1 -> 0; a byte-3 read held for 5 cycles pops once.
- Push pFIFO_DEPTH+3 words -> full=1, count=512, overflow=1; first word read equals the first word pushed; write CTRL=0x03 -> count=0, overflow=0, arm=1.
- With FIFO full, push and pop in the same cycle -> count stays 512, no overflow; with arm=0, trace_valid pulses leave count unchanged.
- Assert rst_n low while reg_read is high on DATA byte 3 -> no pop after release, count=0, reg_datai=0.
